// File: rtl/pe_pkg.sv
// pe_pkg: shared sizes, element index type and scan FSM states for the PE sparse output encoder.
// No ports; imported by pe_out_stage and pe_sparse_out_encoder.
package pe_pkg;
    localparam int CH       = 32;
    localparam int NUM_ROWS = 3;
    localparam int DW       = 16;
    localparam int CW       = 8;
    localparam int SW       = 4;
    localparam int NUM_EL   = NUM_ROWS * CH;
    localparam int EW       = $clog2(NUM_EL);
    localparam int LW       = $clog2(CH) + 1;
    localparam int TW       = $clog2(NUM_EL) + 1;

    typedef logic [EW-1:0] elem_idx_t;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;
endpackage

// File: rtl/pe_out_stage.sv
// pe_out_stage: single-entry valid/ready output register holding one sparse beat.
// Ports: clk_i, rst_ni (async, active-low); load_i with data_i/c_idx_i/row_i writes a beat;
// ready_i is the downstream ready; valid_o/data_o/c_idx_o/row_o present the beat;
// free_o tells the producer a load may happen this cycle.
module pe_out_stage
    import pe_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic signed [DW-1:0] data_i,
    input  logic [CW-1:0]        c_idx_i,
    input  logic [1:0]           row_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic signed [DW-1:0] data_o,
    output logic [CW-1:0]        c_idx_o,
    output logic [1:0]           row_o,
    output logic                 free_o
);
    logic                 valid_q;
    logic signed [DW-1:0] data_q;
    logic [CW-1:0]        c_idx_q;
    logic [1:0]           row_q;

    // Free when empty or the held beat leaves this cycle, allowing full-rate back-to-back loads.
    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign c_idx_o = c_idx_q;
    assign row_o   = row_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            c_idx_q <= '0;
            row_q   <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            c_idx_q <= c_idx_i;
            row_q   <= row_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/pe_sparse_out_encoder.sv
// pe_sparse_out_encoder: captures the dense PE output buffer, shifts/ReLUs it and streams nonzeros.
// Ports: i_clk, i_rst_n (async, active-low); i_start captures i_feature/i_shift/i_relu_en;
// o_valid/i_ready handshake o_data/o_c_idx/o_row beats; o_row_done/o_row_len report each row;
// o_nnz_total counts the job's nonzeros; o_busy marks an active job; o_finish pulses once drained.
module pe_sparse_out_encoder
    import pe_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [NUM_EL-1:0][DW-1:0]  i_feature,
    input  logic [SW-1:0]              i_shift,
    input  logic                       i_relu_en,
    output logic                       o_busy,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic signed [DW-1:0]       o_data,
    output logic [CW-1:0]              o_c_idx,
    output logic [1:0]                 o_row,
    output logic                       o_row_done,
    output logic [LW-1:0]              o_row_len,
    output logic [TW-1:0]              o_nnz_total,
    output logic                       o_finish
);
    state_t                     state_q, state_d;
    elem_idx_t                  ptr_q, ptr_d;
    logic [NUM_EL-1:0][DW-1:0]  feat_q;
    logic [SW-1:0]              shift_q;
    logic                       relu_q;
    logic [LW-1:0]              row_cnt_q, row_cnt_d, row_len_q, row_len_d;
    logic [TW-1:0]              nnz_q, nnz_d;
    logic                       row_done_q, row_done_d, finish_q, finish_d;
    logic                       capture, free, nz, row_end, last;
    logic signed [DW-1:0]       shifted, val;
    logic [1:0]                 cur_row;
    logic [CW-1:0]              cur_ch;

    assign cur_row  = 2'(ptr_q / CH);
    assign cur_ch   = CW'(ptr_q % CH);
    assign shifted  = $signed(feat_q[ptr_q]) >>> shift_q;
    assign val      = (relu_q && shifted[DW-1]) ? '0 : shifted;
    assign nz       = |val;
    assign row_end  = cur_ch == CW'(CH - 1);
    assign last     = ptr_q == elem_idx_t'(NUM_EL - 1);

    assign o_busy      = state_q != S_IDLE;
    assign o_row_done  = row_done_q;
    assign o_row_len   = row_len_q;
    assign o_nnz_total = nnz_q;
    assign o_finish    = finish_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        row_cnt_d  = row_cnt_q;
        row_len_d  = row_len_q;
        nnz_d      = nnz_q;
        row_done_d = 1'b0;
        finish_d   = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            S_IDLE: if (i_start) begin
                capture   = 1'b1;
                ptr_d     = '0;
                row_cnt_d = '0;
                nnz_d     = '0;
                state_d   = S_SCAN;
            end
            // One element per cycle, only when the output register can take a beat.
            S_SCAN: if (free) begin
                ptr_d     = last ? ptr_q : ptr_q + 1'b1;
                row_cnt_d = row_cnt_q + LW'(nz);
                nnz_d     = nnz_q + TW'(nz);
                if (row_end) begin
                    row_done_d = 1'b1;
                    row_len_d  = row_cnt_q + LW'(nz);
                    row_cnt_d  = '0;
                end
                if (last) state_d = S_DRAIN;
            end
            S_DRAIN: if (free) begin
                finish_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            row_cnt_q  <= '0;
            row_len_q  <= '0;
            nnz_q      <= '0;
            row_done_q <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            row_cnt_q  <= row_cnt_d;
            row_len_q  <= row_len_d;
            nnz_q      <= nnz_d;
            row_done_q <= row_done_d;
            finish_q   <= finish_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            feat_q  <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else if (capture) begin
            feat_q  <= i_feature;
            shift_q <= i_shift;
            relu_q  <= i_relu_en;
        end
    end

    pe_out_stage u_out (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .load_i  (state_q == S_SCAN && free && nz),
        .data_i  (val),
        .c_idx_i (cur_ch),
        .row_i   (cur_row),
        .ready_i (i_ready),
        .valid_o (o_valid),
        .data_o  (o_data),
        .c_idx_o (o_c_idx),
        .row_o   (o_row),
        .free_o  (free)
    );
endmodule

// File: tb/tb_pe_sparse_out_encoder.sv
// tb_pe_sparse_out_encoder: randomized self-checking bench against a floor-division reference model.
module tb_pe_sparse_out_encoder;
    import pe_pkg::*;

    typedef struct {int v; int c; int r;} beat_t;

    logic                      i_clk = 1'b0;
    logic                      i_rst_n = 1'b0;
    logic                      i_start = 1'b0;
    logic [NUM_EL-1:0][DW-1:0] i_feature = '0;
    logic [SW-1:0]             i_shift = '0;
    logic                      i_relu_en = 1'b0;
    logic                      i_ready = 1'b0;
    logic                      o_busy, o_valid, o_row_done, o_finish;
    logic signed [DW-1:0]      o_data;
    logic [CW-1:0]             o_c_idx;
    logic [1:0]                o_row;
    logic [LW-1:0]             o_row_len;
    logic [TW-1:0]             o_nnz_total;

    int    checks = 0;
    int    errors = 0;
    int    feat[NUM_EL];
    beat_t exp_q[$];
    int    exp_len[NUM_ROWS];
    int    exp_nnz;

    pe_sparse_out_encoder dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_feature   (i_feature),
        .i_shift     (i_shift),
        .i_relu_en   (i_relu_en),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_c_idx     (o_c_idx),
        .o_row       (o_row),
        .o_row_done  (o_row_done),
        .o_row_len   (o_row_len),
        .o_nnz_total (o_nnz_total),
        .o_finish    (o_finish)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Arithmetic right shift is floor division by 2^sh.
    function automatic void build_model(input int sh, input bit relu);
        exp_q.delete();
        exp_nnz = 0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            exp_len[r] = 0;
            for (int c = 0; c < CH; c++) begin
                int f;
                int d;
                int v;
                f = feat[r*CH+c];
                d = 1 << sh;
                v = (f >= 0) ? f / d : -((-f + d - 1) / d);
                if (relu && v < 0) v = 0;
                if (v != 0) begin
                    exp_q.push_back('{v, c, r});
                    exp_len[r]++;
                    exp_nnz++;
                end
            end
        end
    endfunction

    task automatic drive_feat();
        for (int i = 0; i < NUM_EL; i++) i_feature[i] = DW'(feat[i]);
    endtask

    task automatic fill(input int val);
        for (int i = 0; i < NUM_EL; i++) feat[i] = val;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_data"}, o_data, 0);
        check({tag, "_c_idx"}, o_c_idx, 0);
        check({tag, "_row"}, o_row, 0);
        check({tag, "_row_done"}, o_row_done, 0);
        check({tag, "_row_len"}, o_row_len, 0);
        check({tag, "_nnz"}, o_nnz_total, 0);
        check({tag, "_finish"}, o_finish, 0);
    endtask

    // mode 0: ready always high, 1: toggling, 2: random.
    task automatic run_job(input int sh, input bit relu, input int mode, input bit restart);
        int                   cyc;
        int                   rows;
        bit                   done;
        bit                   stall;
        int                   pd, pc, pr;
        beat_t                b;
        cyc   = 0;
        rows  = 0;
        done  = 0;
        stall = 0;
        pd = 0; pc = 0; pr = 0;
        build_model(sh, relu);
        @(negedge i_clk);
        drive_feat();
        i_shift   = SW'(sh);
        i_relu_en = relu;
        i_start   = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        while (!done && cyc < 1000) begin
            cyc++;
            if (cyc == 1) check("busy_start", o_busy, 1);
            if (restart && cyc == 10) begin
                for (int i = 0; i < NUM_EL; i++) i_feature[i] = DW'($urandom);
                i_shift   = SW'($urandom);
                i_relu_en = ~relu;
                i_start   = 1'b1;
            end else if (restart && cyc == 11) begin
                i_start = 1'b0;
            end
            if (stall) begin
                check("stall_valid", o_valid, 1);
                check("stall_data", o_data, pd);
                check("stall_c_idx", o_c_idx, pc);
                check("stall_row", o_row, pr);
            end
            if (o_row_done) begin
                if (rows < NUM_ROWS) check("row_len", o_row_len, exp_len[rows]);
                else check("row_done_count", rows + 1, NUM_ROWS);
                rows++;
            end
            if (o_finish) begin
                if (mode == 0) check("finish_cycle", cyc, 98);
                check("beats_left", exp_q.size(), 0);
                check("rows_done", rows, NUM_ROWS);
                check("nnz_total", o_nnz_total, exp_nnz);
                done = 1;
            end
            i_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) check("beat_expected", exp_q.size(), 1);
                else begin
                    b = exp_q.pop_front();
                    check("beat_data", o_data, b.v);
                    check("beat_c_idx", o_c_idx, b.c);
                    check("beat_row", o_row, b.r);
                end
            end
            stall = o_valid && !i_ready;
            pd = o_data;
            pc = o_c_idx;
            pr = o_row;
            if (!done) @(negedge i_clk);
        end
        check("finish_seen", done, 1);
        @(negedge i_clk);
        check("busy_after", o_busy, 0);
        check("valid_after", o_valid, 0);
        check("nnz_hold", o_nnz_total, exp_nnz);
    endtask

    initial begin
        int fin;
        repeat (2) @(negedge i_clk);
        check_idle_outputs("reset");
        i_rst_n = 1'b1;

        fill(5);
        drive_feat();
        @(negedge i_clk);
        i_ready = 1'b0;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        check("pre_reset_valid", o_valid, 1);
        i_rst_n = 1'b0;
        #1;
        check_idle_outputs("midjob_reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        fin = 0;
        repeat (120) begin
            @(negedge i_clk);
            fin += int'(o_finish);
        end
        check("no_finish_after_reset", fin, 0);

        fill(0);
        run_job(0, 1'b0, 0, 1'b0);

        fill(0);
        feat[CH+5]  = 100;
        feat[CH+31] = -7;
        run_job(0, 1'b1, 0, 1'b0);

        fill(64);
        run_job(3, 1'b0, 0, 1'b0);
        run_job(3, 1'b0, 1, 1'b0);

        fill(0);
        feat[7] = -256;
        run_job(4, 1'b0, 0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NUM_EL; i++)
                feat[i] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 65535) - 32768;
            run_job((k < 2) ? 15 : $urandom_range(0, 15), 1'(k), (k < 2) ? 0 : 2, 1'(k == 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_sparse_out_encoder.md
Name: pe_sparse_out_encoder

Overview:
Output-side counterpart of the PE's sparse input format. The PE consumes sparse IA bundles (data plus channel index plus length); this block produces them. It captures the PE's dense output feature buffer (NUM_ROWS x CH values) on the PE finish pulse. It applies arithmetic shift and ReLU, drops zeros, and streams the surviving (value, channel index, row) beats over valid/ready. Each row reports its nonzero length, so the result can be fed back as the next layer's IA bundle.

Parameters:
CH, 32, channels per output row (matches IA_CHANNEL)
NUM_ROWS, 3, output rows held by the PE output buffer
DW, 16, signed data width (matches IA_DATA_BITWIDTH)
CW, 8, channel index width (matches IA_C_BITWIDTH)
SW, 4, shift amount width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  capture pulse (tied to PE o_finish)
i_feature  in  DW x NUM_ROWS*CH  signed dense PE output; element index = row*CH + ch
i_shift  in  SW  arithmetic right-shift amount, sampled with i_start
i_relu_en  in  1  1 = clamp negatives to 0, sampled with i_start
o_busy  out  1  high from the cycle after start acceptance until o_finish
o_valid  out  1  output beat valid
i_ready  in  1  downstream ready
o_data  out  DW  signed shifted/ReLU'd value
o_c_idx  out  CW  channel index 0..CH-1
o_row  out  2  row index 0..NUM_ROWS-1
o_row_done  out  1  one-cycle pulse when a row's scan completes
o_row_len  out  $clog2(CH)+1  nonzero count of the completed row; valid with o_row_done
o_nnz_total  out  $clog2(NUM_ROWS*CH)+1  running job nonzero count; holds after finish
o_finish  out  1  one-cycle pulse when the job is fully drained

Behaviour:
- Reset: all outputs 0; state S_IDLE; capture buffer, pointer and counters cleared. Reset mid-job aborts the job immediately; no finish pulse is produced.
- States:
  - S_IDLE: i_start=1 captures i_feature, i_shift and i_relu_en into internal registers, clears the pointer and counters, then goes to S_SCAN. i_start in any other state is ignored, with no re-capture.
  - S_SCAN: evaluates one element per cycle at pointer p (row = p / CH, ch = p % CH), but only when the output register is free. Free means o_valid=0, or o_valid=1 with i_ready=1.
  - S_DRAIN: entered after element NUM_ROWS*CH-1 is evaluated. Waits until o_valid=0 or the final beat is accepted, then pulses o_finish for 1 cycle and goes to S_IDLE.
- Element evaluation: v = feature >>> shift, sign-preserving. If i_relu_en is set and v < 0, then v = 0. If v != 0, load o_data/o_c_idx/o_row and set o_valid. If v == 0, skip with no beat; zeros cost 1 cycle each.
- Handshake: a beat transfers when o_valid && i_ready. While o_valid && !i_ready, o_data/o_c_idx/o_row/o_valid must hold stable. o_valid drops the cycle after acceptance unless a new nonzero loads in that same cycle (back-to-back at full rate).
- Row bookkeeping: the row counter increments on each loaded nonzero.
  - When the element with ch = CH-1 is evaluated, o_row_done pulses the next cycle with o_row_len = that row's count, including a load made by the final element. The row counter then clears.
  - Empty rows still pulse o_row_done with o_row_len = 0.
  - o_row_done is independent of i_ready.
- o_nnz_total increments per loaded nonzero and is cleared at start acceptance.
- Latency: start accepted at cycle T; element 0 evaluated at T+1; its beat is visible at T+2. With all nonzero and i_ready=1: 96 beats at T+2..T+97, o_finish at T+98. With all zero: o_finish at T+98, and o_valid never asserts.
- Shift of DW-1 or more yields 0 or -1; ReLU then maps -1 to 0.

Decomposition:
- Package pe_pkg: CH, NUM_ROWS, DW, CW, SW, the element index type, and the state enum {S_IDLE, S_SCAN, S_DRAIN}.
- One sub-module: pe_out_stage, a single-entry output register with the valid/ready hold logic and a load-enable "free" output.
- Scan, shift/ReLU and counters stay in the top block.

Test Plan:
1. Reset with o_valid pending (mid-job): all outputs 0 within the reset cycle; no o_finish follows; a new i_start works normally.
2. Feature all 0, i_ready=1: no beats; three o_row_done pulses with len 0; o_finish at T+98; o_nnz_total=0.
3. Row 1 ch5=100, ch31=-7, relu_en=1, shift=0: exactly one beat (data 100, c_idx 5, row 1); row lens 0,1,0; o_nnz_total=1.
4. All elements = 64, shift=3, i_ready=1: 96 back-to-back beats of data 8 with c_idx 0..31 per row; each row_len=32; o_finish at T+98.
5. Same data with i_ready toggling 1/0 each cycle: beat contents stable during stalls; no beat lost or duplicated; o_finish only after the 96th acceptance.
6. relu_en=0, element -256, shift=4: beat data -16. A second i_start while busy is ignored, and the buffer is unchanged.
